// File: rtl/prog_load_if.sv
// Bus between the program-load controller and its surroundings: the load
// request from the board, the boot-ROM read port, the IMEM write port with
// its ready handshake, and the status/hold signals seen by the processor.
interface prog_load_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();
  logic              load_req;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              imem_ready;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   words_loaded;

  // Controller side
  modport master (
    input  load_req, rom_data, imem_ready,
    output rom_addr, imem_we, imem_addr, imem_wdata,
           cpu_hold, busy, done, words_loaded
  );

  // Environment side: request source, ROM, IMEM, processor
  modport slave (
    output load_req, rom_data, imem_ready,
    input  rom_addr, imem_we, imem_addr, imem_wdata,
           cpu_hold, busy, done, words_loaded
  );
endinterface

// File: rtl/prog_load_ctrl.sv
// Program-load controller: on a rising edge of the (synchronised) load
// request it holds the CPU, copies ROM_DEPTH words from the boot ROM into
// instruction memory one READ/WAIT/WRITE triplet at a time, then releases
// the CPU and pulses done. All bus outputs come straight from flops.
module prog_load_ctrl #(
  parameter int ROM_DEPTH = 256,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter int HOLD_CYC  = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  prog_load_if.master   bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);
  localparam logic [3:0]        HOLD_LAST = 4'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic              sync_q1, sync_q2;
  logic [3:0]        hold_cnt_q, hold_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              imem_we_q, imem_we_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              start_s;

  // Rising edge of the synchronised request; only honoured in IDLE.
  assign start_s = sync_q1 & ~sync_q2;

  // Two-flop synchroniser for the asynchronous button request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= bus.load_req;
      sync_q2 <= sync_q1;
    end
  end

  // Next-state, datapath and output decode for the copy sequence.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    addr_d     = addr_q;
    rom_addr_d = rom_addr_q;
    wdata_d    = wdata_q;
    words_d    = words_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) begin
          state_d    = ST_HOLD;
          words_d    = '0;
          addr_d     = '0;
          hold_cnt_d = 4'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_READ;
          rom_addr_d = addr_q;   // address is presented during the READ cycle
        end else begin
          hold_cnt_d = hold_cnt_q + 4'd1;
        end
      end
      ST_READ: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        wdata_d = bus.rom_data;  // ROM data valid one cycle after the address
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (imem_we_q && bus.imem_ready) begin
          words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
          if (addr_q == LAST_ADDR) begin
            state_d = ST_DONE;
          end else begin
            addr_d     = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            rom_addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            state_d    = ST_READ;
          end
        end else begin
          state_d = ST_WRITE;    // stall: address/data/we held by their flops
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    imem_we_d  = (state_d == ST_WRITE);
    cpu_hold_d = (state_d != ST_IDLE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State, datapath and output registers; reset drops everything to idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= 4'd0;
      addr_q     <= '0;
      rom_addr_q <= '0;
      wdata_q    <= '0;
      words_q    <= '0;
      imem_we_q  <= 1'b0;
      cpu_hold_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      wdata_q    <= wdata_d;
      words_q    <= words_d;
      imem_we_q  <= imem_we_d;
      cpu_hold_q <= cpu_hold_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.imem_we      = imem_we_q;
  assign bus.imem_addr    = addr_q;
  assign bus.imem_wdata   = wdata_q;
  assign bus.cpu_hold     = cpu_hold_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.words_loaded = words_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Bench for prog_load_ctrl: ROM and IMEM models on the bus, a per-cycle
// reference model of the load sequence, and directed/random load scenarios.
module tb_prog_load_ctrl;
  localparam int N  = 256;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  prog_load_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  prog_load_ctrl #(.ROM_DEPTH(N), .ADDR_W(AW), .DATA_W(DW), .HOLD_CYC(H)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ROM: synchronous read, data one cycle after address
  logic [DW-1:0] rom [N];
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // IMEM: records contents and per-address write counts
  logic [DW-1:0] imem [N];
  int            wcount [N];
  int            first_wr_addr;
  logic          clr_req;
  always @(posedge clk) begin
    if (clr_req) begin
      for (int i = 0; i < N; i++) begin
        wcount[i] <= 0;
        imem[i]   <= '0;
      end
      first_wr_addr <= -1;
    end else if (reset_n && bus.imem_we && bus.imem_ready) begin
      imem[bus.imem_addr]   <= bus.imem_wdata;
      wcount[bus.imem_addr] <= wcount[bus.imem_addr] + 1;
      if (first_wr_addr < 0) first_wr_addr <= int'(bus.imem_addr);
    end
  end

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Reference model: mode 0 idle, 1 loading, 2 done cycle. Each word starts
  // with a READ at word_start, WAIT one later, then WRITE until accepted.
  int          mode = 0, t = 0, word_start = 0, idx = 0, m_words = 0;
  bit          lr_d1 = 1'b0, lr_d2 = 1'b0, exp_we = 1'b0;
  logic [AW-1:0] m_rom_addr = '0;

  always @(posedge clk) begin : model_cmp
    bit lr, rdy, start, accept;
    int p;
    lr  = bus.load_req;
    rdy = bus.imem_ready;
    if (!reset_n) begin
      mode = 0; lr_d1 = 1'b0; lr_d2 = 1'b0; m_words = 0; m_rom_addr = '0; exp_we = 1'b0;
    end else begin
      start  = lr_d1 && !lr_d2;
      lr_d2  = lr_d1;
      lr_d1  = lr;
      accept = exp_we && rdy;
      case (mode)
        0: if (start) begin mode = 1; t = 0; idx = 0; word_start = H; m_words = 0; end
        1: begin
          if (accept) begin
            m_words++;
            if (idx == N - 1) mode = 2;
            else begin idx++; word_start = t + 1; end
          end
          t++;
        end
        default: mode = 0;
      endcase
      p      = t - word_start;
      exp_we = (mode == 1) && (p >= 2);
      if (mode == 1 && p == 0) m_rom_addr = AW'(idx);
    end
    #1;
    check("busy", bus.busy, (mode != 0));
    check("cpu_hold", bus.cpu_hold, (mode != 0));
    check("done", bus.done, (mode == 2));
    check("imem_we", bus.imem_we, exp_we);
    check("words_loaded", bus.words_loaded, m_words);
    check("rom_addr", bus.rom_addr, m_rom_addr);
    if (exp_we) begin
      check("imem_addr", bus.imem_addr, idx);
      check("imem_wdata", bus.imem_wdata, rom[idx]);
    end
  end

  task automatic clear_mem();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
  endtask

  task automatic verify_imem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (imem[i] !== rom[i] || wcount[i] != 1) begin
        bad++;
        if (bad <= 4)
          $display("FAIL %s_word%0d actual=%0d/%0d required=%0d/1", tag, i, imem[i], wcount[i], rom[i]);
      end
    end
    check({tag, "_bad_words"}, bad, 0);
  endtask

  // Starts a load at a negedge and runs it to done (dur = edges taken) or
  // abort (dur = -2). Optional single stall, random stalls, mid-load re-pulse.
  task automatic run_load(input bit keep_high, input int stall_word, input int stall_len,
                          input bit rand_stall, input int abort_word, output int dur);
    int c0, cnt;
    bit stalled;
    c0 = edge_cnt; cnt = 0; stalled = 1'b0; dur = -1;
    bus.load_req = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("start_busy", bus.busy, 1);
        check("start_words", bus.words_loaded, 0);
      end
      if (!keep_high && k == 2) bus.load_req = 1'b0;
      if (keep_high && k == 300) bus.load_req = 1'b0;
      if (keep_high && k == 302) bus.load_req = 1'b1;
      if (bus.done) begin dur = edge_cnt - c0; break; end
      if (bus.imem_we && int'(bus.imem_addr) == abort_word) begin
        reset_n = 1'b0;
        #1;
        check("abort_cpu_hold", bus.cpu_hold, 0);
        check("abort_imem_we", bus.imem_we, 0);
        check("abort_busy", bus.busy, 0);
        @(negedge clk);
        reset_n = 1'b1;
        dur = -2;
        break;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bus.imem_ready = 1'b1;
      end else if (!stalled && bus.imem_we && int'(bus.imem_addr) == stall_word) begin
        bus.imem_ready = 1'b0; cnt = stall_len; stalled = 1'b1;
      end else if (rand_stall) begin
        bus.imem_ready = ($urandom_range(0, 3) != 0);
      end
    end
    bus.imem_ready = 1'b1;
    if (dur == -1) begin
      checks++; failures++;
      $display("FAIL load_timeout actual=no_done required=done");
    end
  endtask

  initial begin
    int dur, extra_done, extra_busy;
    reset_n = 1'b0; bus.load_req = 1'b0; bus.imem_ready = 1'b1; clr_req = 1'b0;
    for (int i = 0; i < N; i++) rom[i] = DW'(i * 3);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // idle after reset: everything stays low
    repeat (100) @(negedge clk);
    check("idle_imem_addr", bus.imem_addr, 0);
    check("idle_imem_wdata", bus.imem_wdata, 0);
    check("idle_words", bus.words_loaded, 0);

    // full load, no stalls: HOLD + 3/word + 1 after the synced edge
    clear_mem();
    run_load(1'b0, -1, 0, 1'b0, -1, dur);
    check("t2_latency", dur, 774);
    check("t2_words", bus.words_loaded, 256);
    check("t2_imem10", imem[10], 30);
    @(negedge clk);
    check("t2_cpu_hold_after", bus.cpu_hold, 0);
    check("t2_busy_after", bus.busy, 0);
    verify_imem("t2");

    // 5-cycle stall on word 10
    clear_mem();
    run_load(1'b0, 10, 5, 1'b0, -1, dur);
    check("t3_latency", dur, 779);
    check("t3_word10_writes", wcount[10], 1);
    verify_imem("t3");

    // request held high with a re-pulse mid-load: only one load
    clear_mem();
    run_load(1'b1, -1, 0, 1'b0, -1, dur);
    check("t4_latency", dur, 774);
    extra_done = 0; extra_busy = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done) extra_done++;
      if (bus.busy) extra_busy++;
    end
    check("t4_extra_done", extra_done, 0);
    check("t4_extra_busy", extra_busy, 0);
    verify_imem("t4");
    bus.load_req = 1'b0;
    repeat (4) @(negedge clk);

    // reset at word 100, then a fresh load from address 0
    clear_mem();
    run_load(1'b0, -1, 0, 1'b0, 100, dur);
    check("t5_aborted", dur, -2);
    check("t5_word99_kept", wcount[99], 1);
    check("t5_word100_unwritten", wcount[100], 0);
    bus.load_req = 1'b0;
    repeat (4) @(negedge clk);
    clear_mem();
    run_load(1'b0, -1, 0, 1'b0, -1, dur);
    check("t5_first_addr", first_wr_addr, 0);
    check("t5_latency", dur, 774);
    verify_imem("t5");

    // back-to-back loads
    clear_mem();
    run_load(1'b0, -1, 0, 1'b0, -1, dur);
    @(negedge clk);
    clear_mem();
    run_load(1'b0, -1, 0, 1'b0, -1, dur);
    check("t6_latency", dur, 774);
    check("t6_words", bus.words_loaded, 256);
    verify_imem("t6");

    // random ROM contents with random IMEM back-pressure
    for (int i = 0; i < N; i++) rom[i] = $urandom;
    repeat (3) @(negedge clk);
    clear_mem();
    run_load(1'b0, -1, 0, 1'b1, -1, dur);
    check("t7_min_latency", (dur >= 774), 1);
    verify_imem("t7");
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
